cpu_hazard_ctrl: RTL and testbench
==================================

Name: cpu_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage CPU (IF/DEC/EXEC/MEM/WB), 16 architectural registers.
- Replaces per-stage register-compare stall logic with a per-register pending-write scoreboard.
- Sequences jump/branch resolution through a small FSM: fetch holds until EXEC resolves, then a one-cycle flush if the branch is taken.
- Sits beside the IF/DEC boundary and drives the stall, issue and flush controls for the IF/DEC pipeline register.

Parameters:
- NUM_REGS, 16, architectural register count; index width is log2(NUM_REGS)=4.
- CNT_W, 3, width of each per-register in-flight write counter.
- PERF_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  IF holds a valid instruction.
- if_rd_a_en  in  1  instruction reads source A.
- if_rd_a  in  4  source A register (instr[19:16]).
- if_rd_b_en  in  1  instruction reads source B.
- if_rd_b  in  4  source B register (instr[15:12]).
- if_wrt_en  in  1  instruction writes a register.
- if_wrt_reg  in  4  destination register.
- if_jb  in  1  instruction is a jump/branch.
- ex_jb_resolve  in  1  single-cycle pulse: EXEC resolved the outstanding jump/branch.
- ex_jb_taken  in  1  qualifier for ex_jb_resolve: branch taken.
- wb_wrt_en  in  1  WB commits a register write this cycle.
- wb_wrt_reg  in  4  WB destination register.
- rw_stall  out  1  data hazard: hold IF, insert bubble into DEC.
- jb_stall  out  1  control hazard: hold IF.
- issue  out  1  IF instruction advances into DEC this cycle.
- flush  out  1  kill the instruction currently in IF.
- pending  out  16  bit r = 1 when register r has ≥1 write in flight.
- stall_cnt  out  PERF_W  saturating count of cycles with if_valid & ~issue.
- sb_err  out  1  sticky: WB retired a register whose counter was 0.

Behaviour:
- Reset (async, rst_n=0): all counters 0, FSM=RUN, sb_err=0, stall_cnt=0. Outputs: rw_stall=jb_stall=issue=flush=0, pending=0.
- Scoreboard: one CNT_W counter per register.
  - issue & if_wrt_en increments cnt[if_wrt_reg].
  - wb_wrt_en decrements cnt[wb_wrt_reg].
  - Issue and retire of the same register in one cycle leave the count unchanged.
  - Retire with cnt=0: count stays 0, sb_err is set and stays set until reset.
- pending[r] = (cnt[r] != 0). Driven from registered state only.
- rw_stall is combinational from registered counts; there is no same-cycle WB bypass. It is asserted when if_valid and any of:
  - if_rd_a_en & cnt[if_rd_a] != 0
  - if_rd_b_en & cnt[if_rd_b] != 0
  - if_wrt_en & cnt[if_wrt_reg] == max (all ones; prevents overflow)
- A read whose only producer retires this cycle stalls exactly one more cycle.
- FSM:
  - RUN: jb_stall=0. If issue & if_jb, go to JB_WAIT next cycle.
  - JB_WAIT: jb_stall=1 while if_valid. On ex_jb_resolve: go to FLUSH if ex_jb_taken, otherwise go to RUN.
  - FLUSH: flush=1 and jb_stall=1 for exactly one cycle, then go to RUN.
  - ex_jb_resolve while in RUN or FLUSH is ignored.
- issue = if_valid & ~rw_stall & ~jb_stall & ~flush.
- Only one jump/branch is in flight at a time. No younger instruction issues behind a branch, so a flush never adjusts counters.
- stall_cnt increments when if_valid & ~issue and saturates at all ones.
- Mid-operation reset returns immediately to the reset state: counters cleared, FSM=RUN, and any in-progress flush is abandoned.

Test Plan:
- Reset with random inputs driven, then release: pending=0, issue=0 until if_valid; with if_valid=1, no reads and no jb, issue=1 on the first cycle.
- Write r3 (issue), then next cycle a reader with rd_a=r3: rw_stall=1 and pending[3]=1. Pulse wb_wrt_en with reg 3: rw_stall stays 1 that cycle and drops the following cycle; issue=1; stall_cnt matches the number of stalled cycles.
- Issue a write to r5 in the same cycle WB retires r5 (count was 1): cnt stays 1, pending[5]=1. A second retire of r5 clears it; a third retire sets sb_err=1, which stays 1.
- Issue a jb: jb_stall=1 for the following cycles. Pulse ex_jb_resolve with taken=1: the next cycle flush=1 and issue=0, then RUN resumes and issue=1. Repeat with taken=0: no flush cycle.
- Issue 7 writes to r1 without retire: the 8th writer to r1 gets rw_stall=1; one WB retire of r1 lets it issue the next cycle.
- Assert rst_n=0 during JB_WAIT with pending=0x0008: asynchronously pending=0 and jb_stall=0; after release, the FSM is in RUN.

Source files
------------

// File: rtl/cpu_hazard_ctrl_if.sv
// Control bundle between the IF/DEC boundary, EXEC/WB feedback and the hazard controller.
// The instruction transfers from IF into DEC on a cycle where if_valid & issue are both high;
// IF holds the instruction and its decode fields stable until that cycle.
interface cpu_hazard_ctrl_if #(
  parameter int NUM_REGS = 16,
  parameter int PERF_W   = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
);
  logic              if_valid;
  logic              if_rd_a_en;
  logic [IDX_W-1:0]  if_rd_a;
  logic              if_rd_b_en;
  logic [IDX_W-1:0]  if_rd_b;
  logic              if_wrt_en;
  logic [IDX_W-1:0]  if_wrt_reg;
  logic              if_jb;
  logic              ex_jb_resolve;
  logic              ex_jb_taken;
  logic              wb_wrt_en;
  logic [IDX_W-1:0]  wb_wrt_reg;

  logic              rw_stall;
  logic              jb_stall;
  logic              issue;
  logic              flush;
  logic [NUM_REGS-1:0] pending;
  logic [PERF_W-1:0] stall_cnt;
  logic              sb_err;
  logic [1:0]        fsm_state;

  modport master (
    output if_valid, if_rd_a_en, if_rd_a, if_rd_b_en, if_rd_b, if_wrt_en, if_wrt_reg,
           if_jb, ex_jb_resolve, ex_jb_taken, wb_wrt_en, wb_wrt_reg,
    input  rw_stall, jb_stall, issue, flush, pending, stall_cnt, sb_err, fsm_state
  );

  modport slave (
    input  if_valid, if_rd_a_en, if_rd_a, if_rd_b_en, if_rd_b, if_wrt_en, if_wrt_reg,
           if_jb, ex_jb_resolve, ex_jb_taken, wb_wrt_en, wb_wrt_reg,
    output rw_stall, jb_stall, issue, flush, pending, stall_cnt, sb_err, fsm_state
  );
endinterface

// File: rtl/cpu_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: per-register pending-write scoreboard for data
// hazards plus a jump/branch FSM that holds fetch until EXEC resolves and flushes when taken.
module cpu_hazard_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 3,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_hazard_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_JB_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nonzero;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                rw_stall;
  logic                jb_stall;
  logic                flush;
  logic                issue;
  logic                sb_err;
  logic [PERF_W-1:0]   stall_cnt;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      nonzero[r] = (cnt[r] != '0);
      inc_vec[r] = issue && bus.if_wrt_en && (bus.if_wrt_reg == IDX_W'(r));
      dec_vec[r] = bus.wb_wrt_en && (bus.wb_wrt_reg == IDX_W'(r));
    end
  end

  // Looks only at registered counts: a producer retiring this cycle still blocks its readers.
  always_comb begin
    rw_stall = 1'b0;
    if (bus.if_valid) begin
      if (bus.if_rd_a_en && nonzero[bus.if_rd_a])       rw_stall = 1'b1;
      if (bus.if_rd_b_en && nonzero[bus.if_rd_b])       rw_stall = 1'b1;
      if (bus.if_wrt_en && cnt[bus.if_wrt_reg] == CNT_MAX) rw_stall = 1'b1;
    end
  end

  always_comb begin
    flush    = (state == ST_FLUSH);
    jb_stall = flush || ((state == ST_JB_WAIT) && bus.if_valid);
    issue    = bus.if_valid && !rw_stall && !jb_stall && !flush;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:     if (issue && bus.if_jb) state_nxt = ST_JB_WAIT;
      ST_JB_WAIT: if (bus.ex_jb_resolve) state_nxt = bus.ex_jb_taken ? ST_FLUSH : ST_RUN;
      ST_FLUSH:   state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Simultaneous issue and retire of one register cancel; a retire with nothing in flight is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_W'(1);
        end else if (dec_vec[r] && !inc_vec[r] && nonzero[r]) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err <= 1'b0;
    end else if (|(dec_vec & ~nonzero)) begin
      sb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (bus.if_valid && !issue && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  assign bus.rw_stall  = rw_stall;
  assign bus.jb_stall  = jb_stall;
  assign bus.issue     = issue;
  assign bus.flush     = flush;
  assign bus.pending   = nonzero;
  assign bus.stall_cnt = stall_cnt;
  assign bus.sb_err    = sb_err;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Bench for cpu_hazard_ctrl: directed scenarios followed by random traffic, all checked
// cycle by cycle against a count-based model of in-flight writes and the branch sequence.
module tb_cpu_hazard_ctrl;
  logic clk;
  logic rst_n;

  cpu_hazard_ctrl_if hz ();

  cpu_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hz)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int cnt_m [16];
  bit br_out;
  bit flush_now;
  bit err_m;
  int stall_m;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard of every registered-output value the model predicts
  logic [31:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) cnt_m[r] = 0;
    br_out    = 1'b0;
    flush_now = 1'b0;
    err_m     = 1'b0;
    stall_m   = 0;
  endtask

  task automatic idle_in();
    hz.if_valid      = 1'b0;
    hz.if_rd_a_en    = 1'b0;
    hz.if_rd_a       = 4'd0;
    hz.if_rd_b_en    = 1'b0;
    hz.if_rd_b       = 4'd0;
    hz.if_wrt_en     = 1'b0;
    hz.if_wrt_reg    = 4'd0;
    hz.if_jb         = 1'b0;
    hz.ex_jb_resolve = 1'b0;
    hz.ex_jb_taken   = 1'b0;
    hz.wb_wrt_en     = 1'b0;
    hz.wb_wrt_reg    = 4'd0;
  endtask

  task automatic rand_in();
    int start;
    hz.if_valid      = ($urandom_range(0, 3) != 0);
    hz.if_rd_a_en    = $urandom_range(0, 1);
    hz.if_rd_a       = 4'($urandom_range(0, 15));
    hz.if_rd_b_en    = $urandom_range(0, 1);
    hz.if_rd_b       = 4'($urandom_range(0, 15));
    hz.if_wrt_en     = $urandom_range(0, 1);
    hz.if_wrt_reg    = 4'($urandom_range(0, 15));
    hz.if_jb         = ($urandom_range(0, 9) == 0);
    hz.ex_jb_resolve = ($urandom_range(0, 4) == 0);
    hz.ex_jb_taken   = $urandom_range(0, 1);
    hz.wb_wrt_en     = 1'b0;
    hz.wb_wrt_reg    = 4'd0;
    // WB only retires registers that really have a write in flight
    if ($urandom_range(0, 9) < 4) begin
      start = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++) begin
        if (!hz.wb_wrt_en && cnt_m[(start + k) % 16] > 0) begin
          hz.wb_wrt_en  = 1'b1;
          hz.wb_wrt_reg = 4'((start + k) % 16);
        end
      end
    end
  endtask

  // Compare the DUT against the model for the current inputs, then advance the model.
  task automatic step();
    bit rw_e, jb_e, fl_e, iss_e;
    logic [15:0] pend_e;
    int nw [16];
    #1;
    rw_e = hz.if_valid && ((hz.if_rd_a_en && cnt_m[hz.if_rd_a] > 0) ||
                           (hz.if_rd_b_en && cnt_m[hz.if_rd_b] > 0) ||
                           (hz.if_wrt_en  && cnt_m[hz.if_wrt_reg] == 7));
    fl_e  = flush_now;
    jb_e  = flush_now || (br_out && hz.if_valid);
    iss_e = hz.if_valid && !rw_e && !jb_e && !fl_e;
    for (int r = 0; r < 16; r++) pend_e[r] = (cnt_m[r] > 0);

    exp_q.push_back(32'(pend_e));
    exp_q.push_back(32'(stall_m));
    exp_q.push_back(32'(err_m));
    check_val("rw_stall", 32'(hz.rw_stall), 32'(rw_e));
    check_val("jb_stall", 32'(hz.jb_stall), 32'(jb_e));
    check_val("flush",    32'(hz.flush),    32'(fl_e));
    check_val("issue",    32'(hz.issue),    32'(iss_e));
    check_val("pending",   32'(hz.pending),   exp_q.pop_front());
    check_val("stall_cnt", 32'(hz.stall_cnt), exp_q.pop_front());
    check_val("sb_err",    32'(hz.sb_err),    exp_q.pop_front());

    for (int r = 0; r < 16; r++) nw[r] = cnt_m[r];
    if (iss_e && hz.if_wrt_en) nw[hz.if_wrt_reg]++;
    if (hz.wb_wrt_en) begin
      if (cnt_m[hz.wb_wrt_reg] == 0) err_m = 1'b1;
      else nw[hz.wb_wrt_reg]--;
    end
    for (int r = 0; r < 16; r++) cnt_m[r] = nw[r];
    if (hz.if_valid && !iss_e && stall_m < 65535) stall_m++;

    fl_e = 1'b0;
    if (br_out && hz.ex_jb_resolve) begin
      br_out = 1'b0;
      fl_e   = hz.ex_jb_taken;
    end
    if (iss_e && hz.if_jb) br_out = 1'b1;
    flush_now = fl_e;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cyc();
    step();
    tick();
  endtask

  task automatic write_reg(input logic [3:0] r);
    idle_in();
    hz.if_valid = 1'b1; hz.if_wrt_en = 1'b1; hz.if_wrt_reg = r;
    cyc();
  endtask

  task automatic retire_reg(input logic [3:0] r);
    idle_in();
    hz.wb_wrt_en = 1'b1; hz.wb_wrt_reg = r;
    cyc();
  endtask

  int stall_base;

  initial begin
    // reset with random inputs
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rand_in();
      @(negedge clk);
    end
    hz.if_valid = 1'b0;
    #1;
    check_val("rst_pending",  32'(hz.pending),   32'h0);
    check_val("rst_issue",    32'(hz.issue),     32'h0);
    check_val("rst_rw",       32'(hz.rw_stall),  32'h0);
    check_val("rst_jb",       32'(hz.jb_stall),  32'h0);
    check_val("rst_flush",    32'(hz.flush),     32'h0);
    check_val("rst_stall",    32'(hz.stall_cnt), 32'h0);
    check_val("rst_err",      32'(hz.sb_err),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_in();
    cyc();
    hz.if_valid = 1'b1;
    step();
    check_val("first_issue", 32'(hz.issue), 32'h1);
    tick();

    // RAW hazard on r3, released by WB
    write_reg(4'd3);
    stall_base = stall_m;
    idle_in();
    hz.if_valid = 1'b1; hz.if_rd_a_en = 1'b1; hz.if_rd_a = 4'd3;
    step();
    check_val("raw_stall", 32'(hz.rw_stall), 32'h1);
    check_val("raw_pend3", 32'(hz.pending[3]), 32'h1);
    tick();
    hz.wb_wrt_en = 1'b1; hz.wb_wrt_reg = 4'd3;
    step();
    check_val("raw_wb_stall", 32'(hz.rw_stall), 32'h1);
    tick();
    hz.wb_wrt_en = 1'b0;
    step();
    check_val("raw_release", 32'(hz.issue), 32'h1);
    check_val("raw_stallcnt", 32'(hz.stall_cnt), 32'(stall_base + 2));
    tick();

    // same-cycle issue/retire of r5, then underflow
    write_reg(4'd5);
    idle_in();
    hz.if_valid = 1'b1; hz.if_wrt_en = 1'b1; hz.if_wrt_reg = 4'd5;
    hz.wb_wrt_en = 1'b1; hz.wb_wrt_reg = 4'd5;
    cyc();
    idle_in();
    step();
    check_val("r5_still_pend", 32'(hz.pending[5]), 32'h1);
    tick();
    retire_reg(4'd5);
    retire_reg(4'd5);
    idle_in();
    step();
    check_val("r5_clear", 32'(hz.pending[5]), 32'h0);
    check_val("sb_err_set", 32'(hz.sb_err), 32'h1);
    tick();
    cyc();
    check_val("sb_err_sticky", 32'(hz.sb_err), 32'h1);

    // taken then not-taken branch
    for (int t = 1; t >= 0; t--) begin
      idle_in();
      hz.if_valid = 1'b1; hz.if_jb = 1'b1;
      step();
      check_val("jb_issue", 32'(hz.issue), 32'h1);
      tick();
      hz.if_jb = 1'b0;
      for (int k = 0; k < 2; k++) begin
        step();
        check_val("jb_hold", 32'(hz.jb_stall), 32'h1);
        tick();
      end
      hz.ex_jb_resolve = 1'b1; hz.ex_jb_taken = t[0];
      cyc();
      hz.ex_jb_resolve = 1'b0; hz.ex_jb_taken = 1'b0;
      step();
      if (t == 1) begin
        check_val("jb_flush", 32'(hz.flush), 32'h1);
        check_val("jb_flush_noissue", 32'(hz.issue), 32'h0);
        tick();
        step();
      end
      check_val("jb_resume", 32'(hz.issue), 32'h1);
      check_val("jb_noflush", 32'(hz.flush), 32'h0);
      tick();
    end

    // counter saturation on r1
    for (int k = 0; k < 7; k++) write_reg(4'd1);
    idle_in();
    hz.if_valid = 1'b1; hz.if_wrt_en = 1'b1; hz.if_wrt_reg = 4'd1;
    step();
    check_val("ovf_stall", 32'(hz.rw_stall), 32'h1);
    tick();
    hz.wb_wrt_en = 1'b1; hz.wb_wrt_reg = 4'd1;
    cyc();
    hz.wb_wrt_en = 1'b0;
    step();
    check_val("ovf_release", 32'(hz.issue), 32'h1);
    tick();
    for (int k = 0; k < 7; k++) retire_reg(4'd1);

    // asynchronous reset in the middle of a branch wait
    write_reg(4'd3);
    idle_in();
    hz.if_valid = 1'b1; hz.if_jb = 1'b1;
    cyc();
    hz.if_jb = 1'b0;
    step();
    check_val("mid_pend", 32'(hz.pending), 32'h0008);
    check_val("mid_jb", 32'(hz.jb_stall), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_pend", 32'(hz.pending), 32'h0);
    check_val("arst_jb", 32'(hz.jb_stall), 32'h0);
    model_reset();
    tick();
    rst_n = 1'b1;
    step();
    check_val("arst_run", 32'(hz.issue), 32'h1);
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed still running expected finished");
    $fatal(1, "bench timeout");
  end
endmodule
